// File: rtl/mandelbrot_row_scheduler_if.sv
// Bus bundle for the Mandelbrot row scheduler: Avalon-MM register port plus the
// per-core job request/grant/done handshake.
interface mandelbrot_row_scheduler_if #(
    parameter int NUM_ITER = 4,
    parameter int DATA_W   = 27,
    parameter int ROW_W    = 10
);
    logic [2:0]          address;
    logic                chipselect;
    logic                write_n;
    logic [31:0]         writedata;
    logic [31:0]         readdata;
    logic [NUM_ITER-1:0] job_req;
    logic [NUM_ITER-1:0] job_grant;
    logic [DATA_W-1:0]   job_ci;
    logic [DATA_W-1:0]   job_cr;
    logic [ROW_W-1:0]    job_row;
    logic [NUM_ITER-1:0] job_done;
    logic                busy;

    modport master (
        output address, chipselect, write_n, writedata, job_req, job_done,
        input  readdata, job_grant, job_ci, job_cr, job_row, busy
    );

    modport slave (
        input  address, chipselect, write_n, writedata, job_req, job_done,
        output readdata, job_grant, job_ci, job_cr, job_row, busy
    );
endinterface

// File: rtl/mandelbrot_row_scheduler.sv
// Hands out one Mandelbrot row job per cycle to a pool of iterator cores using a
// round-robin arbiter, counts finished rows and times the frame.
module mandelbrot_row_scheduler #(
    parameter int NUM_ITER = 4,
    parameter int DATA_W   = 27,
    parameter int ROW_W    = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    mandelbrot_row_scheduler_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_ITER);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   ci_init;
    logic [DATA_W-1:0]   cr_init;
    logic [DATA_W-1:0]   dci;
    logic [ROW_W-1:0]    num_rows;
    logic [DATA_W-1:0]   ci_acc;
    logic [ROW_W-1:0]    next_row;
    logic [ROW_W-1:0]    rows_done;
    logic [31:0]         cycles;
    logic [PTR_W-1:0]    rr_ptr;
    logic                busy_r;
    logic                done_r;
    logic [NUM_ITER-1:0] grant_r;
    logic [DATA_W-1:0]   job_ci_r;
    logic [DATA_W-1:0]   job_cr_r;
    logic [ROW_W-1:0]    job_row_r;

    logic                wr_en;
    logic                start_cmd;
    logic                abort_cmd;
    logic [NUM_ITER-1:0] avail;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [ROW_W-1:0]    done_cnt;
    logic                unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign abort_cmd    = wr_en && (bus.address == 3'd4) && bus.writedata[1];
    assign start_cmd    = wr_en && (bus.address == 3'd4) && bus.writedata[0] && !bus.writedata[1];
    assign unused_wdata = ^bus.writedata[31:DATA_W];

    // A core granted last cycle still shows its req; mask it so it is not served twice.
    assign avail = bus.job_req & ~grant_r;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_ITER; i++) begin
            if (!pick_valid && avail[(int'(rr_ptr) + i) % NUM_ITER]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'((int'(rr_ptr) + i) % NUM_ITER);
            end
        end
    end

    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < NUM_ITER; i++) begin
            done_cnt = done_cnt + ROW_W'(bus.job_done[i]);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0: bus.readdata = {{(32-DATA_W){ci_init[DATA_W-1]}}, ci_init};
            3'd1: bus.readdata = {{(32-DATA_W){cr_init[DATA_W-1]}}, cr_init};
            3'd2: bus.readdata = {{(32-DATA_W){dci[DATA_W-1]}}, dci};
            3'd3: bus.readdata = 32'(num_rows);
            3'd4: bus.readdata = {30'b0, done_r, busy_r};
            3'd5: bus.readdata = 32'(rows_done);
            3'd6: bus.readdata = cycles;
            default: bus.readdata = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees
    // the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ci_init   <= '0;
            cr_init   <= '0;
            dci       <= '0;
            num_rows  <= '0;
            ci_acc    <= '0;
            next_row  <= '0;
            rows_done <= '0;
            cycles    <= '0;
            rr_ptr    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            grant_r   <= '0;
            job_ci_r  <= '0;
            job_cr_r  <= '0;
            job_row_r <= '0;
        end else begin
            grant_r <= '0;

            if (wr_en && !busy_r) begin
                case (bus.address)
                    3'd0: ci_init  <= bus.writedata[DATA_W-1:0];
                    3'd1: cr_init  <= bus.writedata[DATA_W-1:0];
                    3'd2: dci      <= bus.writedata[DATA_W-1:0];
                    3'd3: num_rows <= bus.writedata[ROW_W-1:0];
                    default: ;
                endcase
            end

            if (abort_cmd) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                done_r <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_cmd) begin
                            rows_done <= '0;
                            cycles    <= '0;
                            next_row  <= '0;
                            ci_acc    <= ci_init;
                            rr_ptr    <= '0;
                            if (num_rows == '0) begin
                                state  <= DONE;
                                done_r <= 1'b1;
                                busy_r <= 1'b0;
                            end else begin
                                state  <= RUN;
                                done_r <= 1'b0;
                                busy_r <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        cycles    <= cycles + 32'd1;
                        rows_done <= rows_done + done_cnt;
                        if (pick_valid) begin
                            grant_r   <= NUM_ITER'(1) << pick_idx;
                            job_ci_r  <= ci_acc;
                            job_cr_r  <= cr_init;
                            job_row_r <= next_row;
                            ci_acc    <= ci_acc + dci;
                            next_row  <= next_row + 1'b1;
                            rr_ptr    <= (pick_idx == PTR_W'(NUM_ITER-1)) ? '0 : pick_idx + 1'b1;
                            if (next_row + 1'b1 == num_rows) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        cycles    <= cycles + 32'd1;
                        rows_done <= rows_done + done_cnt;
                        if (rows_done == num_rows) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.job_grant = grant_r;
    assign bus.job_ci    = job_ci_r;
    assign bus.job_cr    = job_cr_r;
    assign bus.job_row   = job_row_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mandelbrot_row_scheduler.sv
// Directed bench for mandelbrot_row_scheduler: expected grants go into a scoreboard
// queue when a frame is started and are popped by a monitor as grants appear.
module tb_mandelbrot_row_scheduler;
    localparam int NUM_ITER = 4;
    localparam int DATA_W   = 27;
    localparam int ROW_W    = 10;

    typedef struct {
        int                core;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] ci;
        logic [DATA_W-1:0] cr;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [NUM_ITER-1:0] prev_grant = '0;
    logic [31:0] rd;
    logic [DATA_W-1:0] cr_model = '0;

    mandelbrot_row_scheduler_if #(.NUM_ITER(NUM_ITER), .DATA_W(DATA_W), .ROW_W(ROW_W)) bus ();

    mandelbrot_row_scheduler #(.NUM_ITER(NUM_ITER), .DATA_W(DATA_W), .ROW_W(ROW_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of test, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic pulse_done(input logic [NUM_ITER-1:0] p);
        bus.job_done = p;
        @(negedge clk);
        bus.job_done = '0;
    endtask

    // Model of a frame: core order is round-robin from core 0 when all cores ask,
    // otherwise the single requesting core; ci advances modulo 2^DATA_W.
    task automatic expect_rows(input int n, input logic [DATA_W-1:0] ci0,
                               input logic [DATA_W-1:0] step, input int only_core);
        logic [DATA_W-1:0] acc = ci0;
        for (int r = 0; r < n; r++) begin
            exp_t e;
            e.core = (only_core < 0) ? (r % NUM_ITER) : only_core;
            e.row  = ROW_W'(r);
            e.ci   = acc;
            e.cr   = cr_model;
            sb.push_back(e);
            acc = acc + step;
        end
    endtask

    task automatic wait_queue(input int level, input int budget, input string tag);
        int n = 0;
        while (sb.size() > level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(sb.size() > level), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n && bus.job_grant != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(bus.job_grant), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("grant_core", 32'(bus.job_grant), 32'(1) << e.core);
                check("grant_row",  32'(bus.job_row), 32'(e.row));
                check("grant_ci",   32'(bus.job_ci),  32'(e.ci));
                check("grant_cr",   32'(bus.job_cr),  32'(e.cr));
                check("grant_repeat", 32'(bus.job_grant & prev_grant), 32'd0);
            end
        end
        prev_grant = bus.job_grant;
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.job_req    = '0;
        bus.job_done   = '0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.job_grant), 32'd0);
        check("rst_ci",    32'(bus.job_ci), 32'd0);
        check("rst_row",   32'(bus.job_row), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, 32'd0);
        end
        @(negedge clk);

        // Frame 1: all cores request, 8 rows
        cr_model = 27'h7A0_0000;
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h07A0_0000);
        bus_write(3'd2, 32'h0001_0000);
        bus_write(3'd3, 32'd8);
        bus_read(3'd1, rd);
        check("cr_sign_ext", rd, 32'hFFA0_0000);
        @(negedge clk);
        expect_rows(8, 27'h0, 27'h001_0000, -1);
        bus.job_req = 4'hF;
        bus_write(3'd4, 32'h1);
        wait_queue(0, 60, "f1_grants");
        bus.job_req = '0;
        bus_read(3'd4, rd);
        check("f1_drain_status", rd, 32'h1);
        check("f1_hold_row", 32'(bus.job_row), 32'd7);
        check("f1_hold_ci",  32'(bus.job_ci), 32'h0007_0000);
        @(negedge clk);
        pulse_done(4'b0011);
        pulse_done(4'b1100);
        bus_read(3'd5, rd);
        check("f1_rows_done4", rd, 32'd4);
        @(negedge clk);
        pulse_done(4'b1111);
        bus_read(3'd5, rd);
        check("f1_rows_done8", rd, 32'd8);
        repeat (2) @(negedge clk);
        bus_read(3'd4, rd);
        check("f1_done_status", rd, 32'h2);
        @(negedge clk);

        // Frame 2: only core 2 asks, 3 rows
        bus_write(3'd0, 32'h100);
        bus_write(3'd2, 32'h20);
        bus_write(3'd3, 32'd3);
        expect_rows(3, 27'h100, 27'h20, 2);
        bus.job_req = 4'b0100;
        bus_write(3'd4, 32'h1);
        wait_queue(0, 40, "f2_grants");
        bus.job_req = '0;
        check("f2_hold_row", 32'(bus.job_row), 32'd2);
        check("f2_hold_ci",  32'(bus.job_ci), 32'h140);
        repeat (3) pulse_done(4'b0100);
        repeat (2) @(negedge clk);
        bus_read(3'd4, rd);
        check("f2_done_status", rd, 32'h2);
        @(negedge clk);

        // Frame 3: multi-done mid-run, then ABORT (with START in the same write)
        bus_write(3'd0, 32'h0);
        bus_write(3'd2, 32'h1);
        bus_write(3'd3, 32'd20);
        expect_rows(20, 27'h0, 27'h1, 0);
        bus.job_req = 4'b0001;
        bus_write(3'd4, 32'h1);
        wait_queue(16, 40, "f3_four_rows");
        bus_read(3'd5, rd);
        check("f3_rows_before", rd, 32'd0);
        @(negedge clk);
        pulse_done(4'b1111);
        bus_read(3'd5, rd);
        check("f3_rows_multi", rd, 32'd4);
        @(negedge clk);
        bus_write(3'd4, 32'h3);
        sb.delete();
        check("f3_abort_busy", 32'(bus.busy), 32'd0);
        bus_read(3'd4, rd);
        check("f3_abort_status", rd, 32'h0);
        @(negedge clk);
        repeat (3) pulse_done(4'b0001);
        repeat (5) @(negedge clk);
        bus_read(3'd5, rd);
        check("f3_rows_frozen", rd, 32'd4);
        @(negedge clk);

        // Restart after abort: row 0 and the new CI_INIT
        bus_write(3'd0, 32'h3000);
        bus_write(3'd3, 32'd2);
        expect_rows(2, 27'h3000, 27'h1, 0);
        bus_write(3'd4, 32'h1);
        wait_queue(0, 40, "f4_grants");
        bus.job_req = '0;
        pulse_done(4'b0001);
        pulse_done(4'b0001);
        repeat (2) @(negedge clk);
        bus_read(3'd4, rd);
        check("f4_done_status", rd, 32'h2);
        bus_read(3'd5, rd);
        check("f4_rows_done", rd, 32'd2);
        @(negedge clk);

        // NUM_ROWS = 0 goes straight to done without grants
        bus_write(3'd3, 32'd0);
        bus.job_req = 4'hF;
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, rd);
        check("zero_rows_status", rd, 32'h2);
        bus_read(3'd5, rd);
        check("zero_rows_done", rd, 32'd0);
        bus_read(3'd6, rd);
        check("zero_rows_cycles", rd, 32'd0);
        repeat (4) @(negedge clk);
        bus.job_req = '0;
        @(negedge clk);

        // Negative step wraps mod 2^27; config write while busy is ignored
        bus_write(3'd0, 32'h10);
        bus_write(3'd2, 32'h07FF_0000);
        bus_write(3'd3, 32'd4);
        expect_rows(4, 27'h10, 27'h7FF_0000, -1);
        bus.job_req = 4'hF;
        bus_write(3'd4, 32'h1);
        bus_write(3'd0, 32'h1234);
        bus_read(3'd0, rd);
        check("busy_write_ignored", rd, 32'h10);
        bus_read(3'd2, rd);
        check("dci_sign_ext", rd, 32'hFFFF_0000);
        @(negedge clk);
        wait_queue(0, 40, "f6_grants");
        bus.job_req = '0;
        pulse_done(4'hF);
        repeat (2) @(negedge clk);
        bus_read(3'd4, rd);
        check("f6_done_status", rd, 32'h2);
        @(negedge clk);

        // Reset in the middle of a frame
        bus_write(3'd3, 32'd5);
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, rd);
        check("pre_reset_status", rd, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        bus_read(3'd3, rd);
        check("midreset_rows", rd, 32'd0);
        bus_read(3'd6, rd);
        check("midreset_cycles", rd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
